fetch_align_buffer: RTL and testbench
=====================================

FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word-aligned fetch address after reset.
REQ-002 Parameter: DEPTH_HW, 4, halfword buffer capacity; legal values are 4 or greater.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  fetch request for one 32-bit word.
REQ-006 imem_addr  output  32  request address; bits [1:0] always 2'b00.
REQ-007 imem_rvalid  input  1  response strobe for the oldest outstanding request, arriving one or more cycles after the request.
REQ-008 imem_rdata  input  32  response word; halfword 0 is bits [15:0].
REQ-009 redirect  input  1  branch/jump/trap redirect; overrides everything else that cycle.
REQ-010 redirect_pc  input  32  redirect target; bit 0 ignored.
REQ-011 id_ready  input  1  pre-decode stage accepts the presented instruction.
REQ-012 inst_valid_o  output  1  inst_o/inst_pc_o hold a complete instruction.
REQ-013 inst_o  output  32  instruction: {hw1,hw0} if 32-bit, {16'h0,hw0} if compressed.
REQ-014 inst_pc_o  output  32  PC of the presented instruction.
REQ-015 inst_compressed_o  output  1  1 when hw0[1:0] != 2'b11.

Function
REQ-016 Fetch FSM states: F_IDLE (nothing outstanding), F_WAIT (one request outstanding, response kept), F_DROP (one request outstanding, response discarded).
REQ-017 Issue: imem_req=1 only in F_IDLE with count <= DEPTH_HW-2 and no redirect; then go to F_WAIT and advance fetch_pc by 4.
REQ-018 Outstanding requests: never more than one.
REQ-019 F_WAIT + imem_rvalid: push both halfwords, or only hw1 when skip_low=1; clear skip_low; go to F_IDLE.
REQ-020 F_DROP + imem_rvalid: push nothing; go to F_IDLE.
REQ-021 imem_addr = fetch_pc at all times.
REQ-022 Output validity: inst_valid_o = (count>=1 and head[1:0]!=2'b11) or (count>=2).
REQ-023 Presentation: combinational from buffer state; inst_pc_o = head_pc.
REQ-024 Pop: when inst_valid_o & id_ready, pop 1 halfword (compressed) or 2 (32-bit), and add 2 or 4 to head_pc.
REQ-025 Push and pop in the same cycle are both applied; count = count + pushed - popped.
REQ-026 Count stays within 0..DEPTH_HW; the issue rule (REQ-017) guarantees no overflow.
REQ-027 Boundary: a 32-bit instruction with only its low half buffered holds inst_valid_o=0 until the next response arrives.
REQ-028 Redirect, buffer: count:=0, inst_valid_o drops the next cycle, head_pc:={redirect_pc[31:1],1'b0}.
REQ-029 Redirect, fetch: fetch_pc:={redirect_pc[31:2],2'b00}, skip_low:=redirect_pc[1].
REQ-030 Redirect, FSM: from F_WAIT or F_DROP go to F_DROP; from F_IDLE stay in F_IDLE; no request is issued that cycle.
REQ-031 Redirect with imem_rvalid in the same cycle: that response is discarded and the FSM goes to F_IDLE.
REQ-032 Redirect with id_ready in the same cycle: the pop is ignored.

Reset
REQ-033 While reset_n=0: fetch_pc=RESET_PC, head_pc=RESET_PC, count=0, skip_low=0, state=F_IDLE.
REQ-034 Outputs during reset: imem_req=0, inst_valid_o=0, inst_o=0, inst_pc_o=RESET_PC.
REQ-035 First imem_req is asserted in the first cycle after reset_n deasserts.
REQ-036 If reset asserts with a request outstanding, its later response is ignored, because the state is F_IDLE.

Structure
REQ-037 Shared package holds: halfword typedef, fetch-state enum, and an is_compressed(halfword) function, also used by the pre-decode stage.
REQ-038 Sub-module hw_queue: circular halfword FIFO with push 0/1/2 and pop 0/1/2, count output, and flush.

Verification
REQ-039 Reset release with memory latency 1 and words 32'h00A0_0513 at 0x0 and 32'h0000_4501 at 0x4 -> 32-bit instruction 0x00A00513 at PC 0x0, then compressed 0x4501 at PC 0x4.
REQ-040 Compressed at 0x0, 32-bit spanning 0x2-0x5 -> second instruction is presented only after the 0x4 response, with inst_pc_o=0x2 and inst_o={hw@0x4, hw@0x2}.
REQ-041 redirect_pc=0x102 while a request is in F_WAIT -> stale response dropped, next imem_addr=0x100, low half skipped, first inst_pc_o=0x102.
REQ-042 id_ready=0 for 10 cycles -> count saturates at 4, imem_req stays 0, no data is lost after release.
REQ-043 redirect coincident with imem_rvalid and id_ready -> no push, no pop, count=0 the next cycle.
REQ-044 reset_n asserted mid-F_WAIT, then a late imem_rvalid -> ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_align_buffer_pkg.sv
// Shared types for the fetch/align path: halfword type, fetch FSM states and the
// RVC length test that the pre-decode stage also uses.
package fetch_align_buffer_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_buffer_if.sv
// Bundles the instruction-memory port, redirect input and pre-decode handshake
// of the fetch/align buffer.
interface fetch_align_buffer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_compressed_o;

  modport master (
    output imem_req, imem_addr, inst_valid_o, inst_o, inst_pc_o, inst_compressed_o,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid_o, inst_o, inst_pc_o, inst_compressed_o,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_align_buffer_hw_queue.sv
// Circular halfword FIFO: up to two halfwords in and two out per cycle, with flush.
// The two oldest entries are presented combinationally and read as zero when absent.
module fetch_align_buffer_hw_queue
  import fetch_align_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [1:0]            push_cnt,
  input  halfword_t [1:0]       push_data,
  input  logic [1:0]            pop_cnt,
  output halfword_t [1:0]       head,
  output logic [CW-1:0]         count
);

  halfword_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] k);
    int s;
    s = int'(p) + int'(k);
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wrap_add(wr_ptr_reg, push_cnt);
      rd_ptr_reg <= wrap_add(rd_ptr_reg, pop_cnt);
      count_reg  <= count_reg + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && push_cnt != 2'd0) mem[wr_ptr_reg] <= push_data[0];
    if (!flush && push_cnt == 2'd2) mem[wrap_add(wr_ptr_reg, 2'd1)] <= push_data[1];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_head
    assign head[gi] = (count_reg > CW'(gi)) ? mem[wrap_add(rd_ptr_reg, 2'(gi))] : '0;
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch/align buffer: fetches 32-bit words, splits them into halfwords and presents
// whole 16/32-bit instructions to pre-decode, with at most one fetch outstanding.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH_HW = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fetch_align_buffer_if.master  bus
);

  localparam int CW = $clog2(DEPTH_HW + 1);

  fetch_state_t    state_reg, state_next;
  logic [31:0]     fetch_pc_reg, fetch_pc_next;
  logic [31:0]     head_pc_reg, head_pc_next;
  logic            skip_low_reg, skip_low_next;

  logic [CW-1:0]   count;
  halfword_t [1:0] head;
  halfword_t [1:0] push_data;
  logic [1:0]      push_cnt;
  logic [1:0]      pop_cnt;
  logic            head_compressed;
  logic            inst_valid;
  logic            pop_fire;
  logic            issue;
  logic            rsp_keep;

  fetch_align_buffer_hw_queue #(.DEPTH(DEPTH_HW)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.redirect),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .head      (head),
    .count     (count)
  );

  // Issue only while a full word still fits, so the buffer can never overflow.
  always_comb begin
    head_compressed = is_compressed(head[0]);
    inst_valid      = (count >= CW'(1) && head_compressed) || count >= CW'(2);
    pop_fire        = inst_valid && bus.id_ready && !bus.redirect;
    pop_cnt         = pop_fire ? (head_compressed ? 2'd1 : 2'd2) : 2'd0;
    issue           = reset_n && state_reg == F_IDLE && count <= CW'(DEPTH_HW - 2) && !bus.redirect;
    rsp_keep        = state_reg == F_WAIT && bus.imem_rvalid && !bus.redirect;
    push_cnt        = rsp_keep ? (skip_low_reg ? 2'd1 : 2'd2) : 2'd0;
    push_data[0]    = skip_low_reg ? bus.imem_rdata[31:16] : bus.imem_rdata[15:0];
    push_data[1]    = bus.imem_rdata[31:16];
  end

  always_comb begin
    state_next = state_reg;
    if (bus.redirect) begin
      if (state_reg != F_IDLE) state_next = bus.imem_rvalid ? F_IDLE : F_DROP;
    end else begin
      case (state_reg)
        F_IDLE:         if (issue) state_next = F_WAIT;
        F_WAIT, F_DROP: if (bus.imem_rvalid) state_next = F_IDLE;
        default:        state_next = F_IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    head_pc_next  = head_pc_reg;
    skip_low_next = skip_low_reg;
    if (bus.redirect) begin
      fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
      head_pc_next  = {bus.redirect_pc[31:1], 1'b0};
      skip_low_next = bus.redirect_pc[1];
    end else begin
      if (issue)    fetch_pc_next = fetch_pc_reg + 32'd4;
      if (pop_fire) head_pc_next  = head_pc_reg + (head_compressed ? 32'd2 : 32'd4);
      if (rsp_keep) skip_low_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= F_IDLE;
      fetch_pc_reg <= RESET_PC;
      head_pc_reg  <= RESET_PC;
      skip_low_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      head_pc_reg  <= head_pc_next;
      skip_low_reg <= skip_low_next;
    end
  end

  assign bus.imem_req          = issue;
  assign bus.imem_addr         = fetch_pc_reg;
  assign bus.inst_valid_o      = inst_valid;
  assign bus.inst_o            = !inst_valid ? 32'h0 :
                                 head_compressed ? {16'h0, head[0]} : {head[1], head[0]};
  assign bus.inst_pc_o         = head_pc_reg;
  assign bus.inst_compressed_o = head_compressed;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: a memory responder with random latency and a
// halfword-stream reference model derived directly from memory contents.
module tb_fetch_align_buffer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic clk;
  logic reset_n;
  fetch_align_buffer_if bus ();

  fetch_align_buffer #(.RESET_PC(RESET_PC), .DEPTH_HW(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem [256];
  int n_vec = 0;
  int n_err = 0;

  // Model: head_m = PC of next instruction, fend_m = address just past the last
  // halfword delivered; the buffer holds exactly the halfwords in between.
  logic [31:0] head_m, fend_m, req_addr_m;
  logic        outst_m, drop_m;
  int          lat_m, lat_lo, lat_hi;

  logic        obs_valid, obs_req, obs_comp, exp_valid, exp_req, exp_comp;
  logic [31:0] obs_addr, obs_inst, obs_pc, exp_addr, exp_inst, exp_pc;
  logic [31:0] log_inst [$];
  logic [31:0] log_pc   [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] hw_at(input logic [31:0] p);
    logic [31:0] w;
    w = mem[p[9:2]];
    return p[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] inst_at(input logic [31:0] p);
    logic [15:0] h0, h1;
    h0 = hw_at(p);
    h1 = hw_at(p + 32'd2);
    return (h0[1:0] != 2'b11) ? {16'h0, h0} : {h1, h0};
  endfunction

  function automatic int inst_len(input logic [31:0] p);
    logic [15:0] h0;
    h0 = hw_at(p);
    return (h0[1:0] != 2'b11) ? 2 : 4;
  endfunction

  task automatic model_init();
    head_m = RESET_PC; fend_m = RESET_PC; outst_m = 1'b0; drop_m = 1'b0; lat_m = 0;
  endtask

  // Starts and ends on a falling edge; drives one cycle and records expectations.
  task automatic cycle(input logic rdr, input logic [31:0] rpc, input logic rdy);
    logic rv;
    int   buffered;
    rv = outst_m && lat_m == 0;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    bus.id_ready    = rdy;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem[req_addr_m[9:2]] : $urandom();
    #1;
    buffered  = int'((fend_m - head_m) >> 1);
    exp_comp  = inst_len(head_m) == 2;
    exp_valid = (buffered >= 1 && exp_comp) || buffered >= 2;
    exp_inst  = inst_at(head_m);
    exp_pc    = head_m;
    exp_req   = !outst_m && buffered <= DEPTH - 2 && !rdr;
    exp_addr  = fend_m & ~32'd3;
    obs_valid = bus.inst_valid_o; obs_req = bus.imem_req;  obs_addr = bus.imem_addr;
    obs_inst  = bus.inst_o;       obs_pc  = bus.inst_pc_o; obs_comp = bus.inst_compressed_o;
    if (obs_valid && rdy && !rdr) begin
      log_inst.push_back(obs_inst);
      log_pc.push_back(obs_pc);
    end
    @(posedge clk);
    if (outst_m && !rv) lat_m--;
    if (rdr) begin
      if (rv) outst_m = 1'b0;
      drop_m = outst_m;
      head_m = rpc & ~32'd1;
      fend_m = head_m;
    end else begin
      if (rv) begin
        if (!drop_m) fend_m = req_addr_m + 32'd4;
        outst_m = 1'b0;
        drop_m  = 1'b0;
      end
      if (exp_valid && rdy) head_m = head_m + 32'(inst_len(head_m));
      if (exp_req) begin
        outst_m = 1'b1; drop_m = 1'b0; req_addr_m = exp_addr;
        lat_m = int'($urandom_range(lat_hi, lat_lo));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    model_init();
    log_inst.delete(); log_pc.delete();
    reset_n = 1'b1;
  endtask

  task automatic fill_random_mem();
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    bus.id_ready = 1'b1;
    #1;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b expected 0", bus.imem_req); end
    n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", bus.inst_valid_o); end
    n_vec++; if (bus.inst_o !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h expected 0", bus.inst_o); end
    n_vec++; if (bus.inst_pc_o !== RESET_PC) begin n_err++; $display("FAIL reset_pc: got %h expected %h", bus.inst_pc_o, RESET_PC); end
    repeat (3) @(negedge clk);
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req_hold: got %0b expected 0", bus.imem_req); end
    model_init();
    reset_n = 1'b1;
    lat_lo = 0; lat_hi = 0;
    cycle(1'b0, 32'h0, 1'b0);
    n_vec++; if (obs_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %0b expected 1", obs_req); end
    n_vec++; if (obs_addr !== RESET_PC) begin n_err++; $display("FAIL first_addr: got %h expected %h", obs_addr, RESET_PC); end
  endtask

  task automatic test_boot_sequence();
    mem[0] = 32'h00A0_0513; mem[1] = 32'h0000_4501;
    lat_lo = 0; lat_hi = 0;
    apply_reset();
    for (int i = 0; i < 16 && log_pc.size() < 2; i++) cycle(1'b0, 32'h0, 1'b1);
    n_vec++;
    if (log_pc.size() < 2) begin
      n_err++; $display("FAIL boot_count: got %0d instructions expected 2", log_pc.size());
    end else begin
      n_vec++; if (log_inst[0] !== 32'h00A0_0513) begin n_err++; $display("FAIL boot_inst0: got %h expected 00a00513", log_inst[0]); end
      n_vec++; if (log_pc[0] !== 32'h0) begin n_err++; $display("FAIL boot_pc0: got %h expected 0", log_pc[0]); end
      n_vec++; if (log_inst[1] !== 32'h0000_4501) begin n_err++; $display("FAIL boot_inst1: got %h expected 00004501", log_inst[1]); end
      n_vec++; if (log_pc[1] !== 32'h4) begin n_err++; $display("FAIL boot_pc1: got %h expected 4", log_pc[1]); end
    end
  endtask

  task automatic test_span_boundary();
    mem[0] = 32'h0513_4501; mem[1] = 32'h0001_00A0;
    lat_lo = 1; lat_hi = 1;
    apply_reset();
    for (int i = 0; i < 20 && log_pc.size() < 2; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL span_valid: got %0b expected %0b at head %h", obs_valid, exp_valid, exp_pc); end
    end
    n_vec++;
    if (log_pc.size() < 2) begin
      n_err++; $display("FAIL span_count: got %0d instructions expected 2", log_pc.size());
    end else begin
      n_vec++; if (log_inst[0] !== 32'h0000_4501) begin n_err++; $display("FAIL span_inst0: got %h expected 00004501", log_inst[0]); end
      n_vec++; if (log_pc[1] !== 32'h2) begin n_err++; $display("FAIL span_pc1: got %h expected 2", log_pc[1]); end
      n_vec++; if (log_inst[1] !== 32'h00A0_0513) begin n_err++; $display("FAIL span_inst1: got %h expected 00a00513", log_inst[1]); end
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    fill_random_mem();
    lat_lo = 2; lat_hi = 2;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (outst_m && lat_m > 0) found = 1'b1; else cycle(1'b0, 32'h0, 1'b1);
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL redir_wait_timeout: got %0b expected 1", found); end
    cycle(1'b1, 32'h0000_0102, 1'b1);
    log_inst.delete(); log_pc.delete();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      found = obs_req;
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL redir_req_timeout: got %0b expected 1", found); end
    n_vec++; if (obs_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr: got %h expected 00000100", obs_addr); end
    for (int i = 0; i < 20 && log_pc.size() < 1; i++) cycle(1'b0, 32'h0, 1'b1);
    n_vec++;
    if (log_pc.size() < 1) begin
      n_err++; $display("FAIL redir_none: got 0 instructions expected 1");
    end else begin
      n_vec++; if (log_pc[0] !== 32'h102) begin n_err++; $display("FAIL redir_pc: got %h expected 00000102", log_pc[0]); end
      n_vec++; if (log_inst[0] !== inst_at(32'h102)) begin n_err++; $display("FAIL redir_inst: got %h expected %h", log_inst[0], inst_at(32'h102)); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc;
    fill_random_mem();
    lat_lo = 0; lat_hi = 1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      n_vec++; if (obs_req !== exp_req) begin n_err++; $display("FAIL stall_req: got %0b expected %0b cycle %0d", obs_req, exp_req, i); end
    end
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL stall_full_req: got %0b expected 0", obs_req); end
    n_vec++; if (obs_valid !== 1'b1) begin n_err++; $display("FAIL stall_full_valid: got %0b expected 1", obs_valid); end
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'h0, 1'b1);
    n_vec++; if (log_pc.size() < 4) begin n_err++; $display("FAIL stall_drain: got %0d instructions expected >=4", log_pc.size()); end
    pc = RESET_PC;
    for (int k = 0; k < log_pc.size(); k++) begin
      n_vec++; if (log_pc[k] !== pc || log_inst[k] !== inst_at(pc)) begin
        n_err++; $display("FAIL stall_stream: got %h@%h expected %h@%h", log_inst[k], log_pc[k], inst_at(pc), pc);
      end
      pc = pc + 32'(inst_len(pc));
    end
  endtask

  task automatic test_redirect_coincident();
    logic        found;
    logic [31:0] tgt;
    fill_random_mem();
    lat_lo = 1; lat_hi = 1;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (outst_m && lat_m == 0 && int'((fend_m - head_m) >> 1) >= 2) found = 1'b1;
      else cycle(1'b0, 32'h0, 1'b0);
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL coinc_setup_timeout: got %0b expected 1", found); end
    tgt = 32'($urandom_range(0, 1023)) & ~32'd1;
    cycle(1'b1, tgt, 1'b1);
    log_inst.delete(); log_pc.delete();
    cycle(1'b0, 32'h0, 1'b1);
    n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL coinc_valid: got %0b expected 0", obs_valid); end
    n_vec++; if (obs_req !== 1'b1) begin n_err++; $display("FAIL coinc_req: got %0b expected 1", obs_req); end
    n_vec++; if (obs_addr !== (tgt & ~32'd3)) begin n_err++; $display("FAIL coinc_addr: got %h expected %h", obs_addr, tgt & ~32'd3); end
    for (int i = 0; i < 20 && log_pc.size() < 1; i++) cycle(1'b0, 32'h0, 1'b1);
    n_vec++; if (log_pc.size() < 1 || log_pc[0] !== tgt || log_inst[0] !== inst_at(tgt)) begin
      n_err++; $display("FAIL coinc_first: got %0d insts first pc %h expected %h@%h", log_pc.size(),
                        (log_pc.size() > 0) ? log_pc[0] : 32'hFFFF_FFFF, inst_at(tgt), tgt);
    end
  endtask

  task automatic test_reset_mid_wait();
    fill_random_mem();
    lat_lo = 3; lat_hi = 3;
    apply_reset();
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = $urandom();
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    model_init();
    log_inst.delete(); log_pc.delete();
    reset_n = 1'b1;
    lat_lo = 0; lat_hi = 0;
    cycle(1'b0, 32'h0, 1'b1);
    n_vec++; if (obs_req !== 1'b1) begin n_err++; $display("FAIL rst_wait_req: got %0b expected 1", obs_req); end
    n_vec++; if (obs_addr !== RESET_PC) begin n_err++; $display("FAIL rst_wait_addr: got %h expected %h", obs_addr, RESET_PC); end
    for (int i = 0; i < 15; i++) cycle(1'b0, 32'h0, 1'b1);
    n_vec++; if (log_pc.size() < 1 || log_pc[0] !== RESET_PC || log_inst[0] !== inst_at(RESET_PC)) begin
      n_err++; $display("FAIL rst_wait_first: got %0d insts first %h expected %h@%h", log_pc.size(),
                        (log_inst.size() > 0) ? log_inst[0] : 32'hFFFF_FFFF, inst_at(RESET_PC), RESET_PC);
    end
  endtask

  task automatic test_random();
    logic        rdr, rdy;
    logic [31:0] rpc;
    fill_random_mem();
    lat_lo = 0; lat_hi = 3;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rdr = $urandom_range(0, 39) == 0;
      rpc = 32'($urandom_range(0, 1023));
      rdy = $urandom_range(0, 3) != 0;
      cycle(rdr, rpc, rdy);
      n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid: got %0b expected %0b cycle %0d", obs_valid, exp_valid, i); end
      n_vec++; if (obs_req !== exp_req) begin n_err++; $display("FAIL rnd_req: got %0b expected %0b cycle %0d", obs_req, exp_req, i); end
      if (exp_req) begin
        n_vec++; if (obs_addr !== exp_addr) begin n_err++; $display("FAIL rnd_addr: got %h expected %h cycle %0d", obs_addr, exp_addr, i); end
      end
      if (exp_valid) begin
        n_vec++; if (obs_inst !== exp_inst) begin n_err++; $display("FAIL rnd_inst: got %h expected %h cycle %0d", obs_inst, exp_inst, i); end
        n_vec++; if (obs_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc: got %h expected %h cycle %0d", obs_pc, exp_pc, i); end
        n_vec++; if (obs_comp !== exp_comp) begin n_err++; $display("FAIL rnd_comp: got %0b expected %0b cycle %0d", obs_comp, exp_comp, i); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    idle_inputs();
    fill_random_mem();
    model_init();
    lat_lo = 0; lat_hi = 0;
    @(negedge clk);
    test_reset();
    test_boot_sequence();
    test_span_boundary();
    test_redirect_wait();
    test_stall();
    test_redirect_coincident();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
